// File: rtl/ilv_ctrl_pkg.sv
// Shared types and constants for the interleaver ping-pong controller.
package ilv_ctrl_pkg;

    localparam int unsigned BYTES_6144 = 768;
    localparam int unsigned BYTES_1056 = 132;
    localparam int unsigned CNT_W      = 10;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        BUSY
    } buf_state_e;

    typedef enum logic {
        R_IDLE,
        R_RUN
    } rd_state_e;

    // Number of bytes that make up one block of the given size
    function automatic logic [CNT_W-1:0] target_count(input logic k_size_6144);
        return k_size_6144 ? CNT_W'(BYTES_6144) : CNT_W'(BYTES_1056);
    endfunction

endpackage

// File: rtl/ilv_buf_tracker.sv
// Fill-state tracker for one external shift-register buffer: state,
// byte count, latched block size, shift-enable and clear pulses.
module ilv_buf_tracker
    import ilv_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       rst,
    input  logic       accept,
    input  logic       blk_start,
    input  logic       k_size,
    input  logic       start,
    input  logic       done,
    output buf_state_e state,
    output logic       fill_last,
    output logic       wr_en,
    output logic       clr,
    output logic       err,
    output logic       k_latched
);

    buf_state_e       state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             k_next;
    logic             wr_en_next;
    logic             clr_next;
    logic             err_next;

    // State, counter and pulse registers
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            count     <= '0;
            k_latched <= 1'b0;
            wr_en     <= 1'b0;
            clr       <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            k_latched <= k_next;
            wr_en     <= wr_en_next;
            clr       <= clr_next;
            err       <= err_next;
        end
    end

    // Next-state: release/claim by the read side, byte accounting on writes
    always_comb begin
        state_next = state;
        count_next = count;
        k_next     = k_latched;
        wr_en_next = 1'b0;
        clr_next   = 1'b0;
        err_next   = 1'b0;
        fill_last  = 1'b0;
        if (done) begin
            state_next = EMPTY;
            count_next = '0;
            clr_next   = 1'b1;
        end else if (start) begin
            state_next = BUSY;
        end else if (accept) begin
            case (state)
                EMPTY: begin
                    if (blk_start) begin
                        state_next = FILLING;
                        count_next = CNT_W'(1);
                        k_next     = k_size;
                        wr_en_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                FILLING: begin
                    wr_en_next = 1'b1;
                    if (blk_start) begin
                        // Restart: this byte becomes byte 0 of the new block
                        err_next   = 1'b1;
                        clr_next   = 1'b1;
                        count_next = CNT_W'(1);
                        k_next     = k_size;
                    end else if (count == target_count(k_latched) - CNT_W'(1)) begin
                        fill_last  = 1'b1;
                        state_next = FULL;
                        count_next = '0;
                    end else begin
                        count_next = count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/interleaver_pingpong_ctrl.sv
// Ping-pong controller steering bytes into buffer A/B and handing full
// buffers to the interleaver. Optional macro ILV_BLK_CNT_EN adds the
// blk_done_cnt output counting completed blocks.
module interleaver_pingpong_ctrl
    import ilv_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       rst,
    input  logic       blk_start,
    input  logic       k_size_6144,
    input  logic       byte_valid,
    input  logic [7:0] databyte_in,
    output logic       byte_ready,
    output logic [7:0] wr_byte,
    output logic       wr_en_a,
    output logic       wr_en_b,
    output logic       clr_a,
    output logic       clr_b,
    output logic       rd_sel,
    output logic       ilv_ready_in,
    output logic       ilv_k_size_6144,
    input  logic       process_complete,
    output logic [1:0] buf_full,
    output logic       blk_err
`ifdef ILV_BLK_CNT_EN
    ,
    output logic [15:0] blk_done_cnt
`endif
);

    buf_state_e state_a, state_b;
    logic       fill_last_a, fill_last_b;
    logic       err_a, err_b;
    logic       k_a, k_b;
    logic       live;
    logic       wr_ptr;
    logic       accept;
    buf_state_e ptr_state;

    rd_state_e  rd_state, rd_state_next;
    logic       rd_sel_next;
    logic       ready_next;
    logic       k_out_next;
    logic       rd_err, rd_err_next;
    logic       start_a, start_b, done_a, done_b;
    logic       blk_done;

    assign ptr_state  = wr_ptr ? state_b : state_a;
    assign byte_ready = live && (ptr_state == EMPTY || ptr_state == FILLING);
    assign accept     = byte_valid && byte_ready;
    assign buf_full   = {(state_b == FULL || state_b == BUSY),
                         (state_a == FULL || state_a == BUSY)};
    assign blk_err    = err_a | err_b | rd_err;

    ilv_buf_tracker u_buf_a (
        .clock     (clock),
        .rst       (rst),
        .accept    (accept && !wr_ptr),
        .blk_start (blk_start),
        .k_size    (k_size_6144),
        .start     (start_a),
        .done      (done_a),
        .state     (state_a),
        .fill_last (fill_last_a),
        .wr_en     (wr_en_a),
        .clr       (clr_a),
        .err       (err_a),
        .k_latched (k_a)
    );

    ilv_buf_tracker u_buf_b (
        .clock     (clock),
        .rst       (rst),
        .accept    (accept && wr_ptr),
        .blk_start (blk_start),
        .k_size    (k_size_6144),
        .start     (start_b),
        .done      (done_b),
        .state     (state_b),
        .fill_last (fill_last_b),
        .wr_en     (wr_en_b),
        .clr       (clr_b),
        .err       (err_b),
        .k_latched (k_b)
    );

    // Write side: data register, write pointer toggling on a completed block
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            live    <= 1'b0;
            wr_ptr  <= 1'b0;
            wr_byte <= '0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                wr_byte <= databyte_in;
            end
            if (fill_last_a || fill_last_b) begin
                wr_ptr <= ~wr_ptr;
            end
        end
    end

    // Read FSM state and registered interleaver-side outputs
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            rd_state        <= R_IDLE;
            rd_sel          <= 1'b0;
            ilv_ready_in    <= 1'b0;
            ilv_k_size_6144 <= 1'b0;
            rd_err          <= 1'b0;
        end else begin
            rd_state        <= rd_state_next;
            rd_sel          <= rd_sel_next;
            ilv_ready_in    <= ready_next;
            ilv_k_size_6144 <= k_out_next;
            rd_err          <= rd_err_next;
        end
    end

    // Read FSM next-state: claim a FULL buffer (A preferred), release on completion
    always_comb begin
        rd_state_next = rd_state;
        rd_sel_next   = rd_sel;
        ready_next    = ilv_ready_in;
        k_out_next    = ilv_k_size_6144;
        rd_err_next   = 1'b0;
        start_a       = 1'b0;
        start_b       = 1'b0;
        done_a        = 1'b0;
        done_b        = 1'b0;
        blk_done      = 1'b0;
        case (rd_state)
            R_IDLE: begin
                rd_err_next = process_complete;
                if (state_a == FULL) begin
                    rd_state_next = R_RUN;
                    rd_sel_next   = 1'b0;
                    ready_next    = 1'b1;
                    k_out_next    = k_a;
                    start_a       = 1'b1;
                end else if (state_b == FULL) begin
                    rd_state_next = R_RUN;
                    rd_sel_next   = 1'b1;
                    ready_next    = 1'b1;
                    k_out_next    = k_b;
                    start_b       = 1'b1;
                end
            end
            R_RUN: begin
                if (process_complete) begin
                    rd_state_next = R_IDLE;
                    ready_next    = 1'b0;
                    done_a        = !rd_sel;
                    done_b        = rd_sel;
                    blk_done      = 1'b1;
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

`ifdef ILV_BLK_CNT_EN
    // Completed-block counter, wraps naturally at 16 bits
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            blk_done_cnt <= '0;
        end else if (blk_done) begin
            blk_done_cnt <= blk_done_cnt + 16'd1;
        end
    end
`else
    logic unused_blk_done;
    assign unused_blk_done = blk_done;
`endif

endmodule
